// File: rtl/rap_reg_pkg.sv
// Shared types and defaults for the rapcores register-port arbiter.
package rap_reg_pkg;

  localparam int unsigned ADDR_W_DEF  = 8;
  localparam logic [31:0] WB_BASE_DEF = 32'h3000_0000;
  localparam logic [31:0] WB_MASK_DEF = 32'hFFFF_FC00;

  // Requester bit positions in the arbiter request/grant vectors.
  localparam int unsigned REQ_WB  = 0;
  localparam int unsigned REQ_SPI = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  typedef enum logic {
    GNT_WB  = 1'b0,
    GNT_SPI = 1'b1
  } gnt_e;

  // True when a Wishbone byte address falls inside the register window.
  function automatic logic wb_in_window(input logic [31:0] adr,
                                        input logic [31:0] base,
                                        input logic [31:0] mask);
    return (adr & mask) == base;
  endfunction

endpackage

// File: rtl/rap_reg_arbiter_if.sv
// Wishbone slave bus bundle between the user_project_wrapper pins and the arbiter.
interface rap_reg_arbiter_if;

  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

endinterface

// File: rtl/rap_rr_arb2.sv
// Two-way round-robin arbiter: a lone requester wins, a tie goes to the side
// that was not granted last. The last-grant record advances on update.
module rap_rr_arb2
  import rap_reg_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] gnt
);

  gnt_e last_q, last_d;

  // Grant decode from current requests and the last-grant record.
  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = (last_q == GNT_WB) ? 2'b10 : 2'b01;
    end
  end

  // Remember who was served so the next tie flips to the other side.
  always_comb begin
    last_d = last_q;
    if (update && (gnt != 2'b00)) begin
      last_d = gnt[REQ_SPI] ? GNT_SPI : GNT_WB;
    end
  end

  // Last-grant register; starts as SPI so Wishbone wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= GNT_SPI;
    else        last_q <= last_d;
  end

endmodule

// File: rtl/rap_reg_arbiter.sv
// Shares the rapcores register-file port between the Wishbone slave and the
// SPI command decoder. Each access runs IDLE -> ISSUE -> (WAIT) -> RESP;
// Wishbone accesses outside the window are answered locally with zero data.
module rap_reg_arbiter
  import rap_reg_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = 32,
  parameter logic [31:0] WB_BASE    = WB_BASE_DEF,
  parameter logic [31:0] WB_MASK    = WB_MASK_DEF,
  parameter int unsigned RD_LATENCY = 1   // 1..4
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_n,
  rap_reg_arbiter_if.slave  wb,
  input  logic              spi_req,
  input  logic              spi_we,
  input  logic [ADDR_W-1:0] spi_addr,
  input  logic [DATA_W-1:0] spi_wdata,
  output logic              spi_ack,
  output logic [DATA_W-1:0] spi_rdata,
  output logic              reg_en,
  output logic              reg_we,
  output logic [3:0]        reg_be,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic              busy
);

  // WAIT counts down from here; zero means reg_rdata is valid this cycle.
  localparam logic [1:0] CNT_INIT = 2'(RD_LATENCY - 1);

  state_e            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  gnt_e              src_q, src_d;
  logic              reg_en_q, reg_en_d;
  logic              reg_we_q, reg_we_d;
  logic [3:0]        reg_be_q, reg_be_d;
  logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
  logic [DATA_W-1:0] reg_wdata_q, reg_wdata_d;
  logic              wb_ack_q, wb_ack_d;
  logic [31:0]       wb_dat_q, wb_dat_d;
  logic              spi_ack_q, spi_ack_d;
  logic [DATA_W-1:0] spi_rdata_q, spi_rdata_d;
  logic              busy_q, busy_d;

  logic              wb_req;
  logic              wb_hit;
  logic [1:0]        req;
  logic [1:0]        gnt;
  logic              arb_update;
  logic              resp_go;
  logic [DATA_W-1:0] resp_data;

  assign wb_req     = wb.wbs_cyc_i & wb.wbs_stb_i;
  assign wb_hit     = wb_in_window(wb.wbs_adr_i, WB_BASE, WB_MASK);
  assign req        = {spi_req, wb_req};
  // Requests are only considered in IDLE, so a held request is never accepted twice.
  assign arb_update = (state_q == ST_IDLE);

  rap_rr_arb2 u_arb (
    .clk    (wb_clk_i),
    .rst_n  (wb_rst_n),
    .req    (req),
    .update (arb_update),
    .gnt    (gnt)
  );

  // Access sequencer: next state, latched access fields and response data.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    src_d       = src_q;
    reg_en_d    = 1'b0;
    reg_we_d    = reg_we_q;
    reg_be_d    = reg_be_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    wb_ack_d    = 1'b0;
    wb_dat_d    = wb_dat_q;
    spi_ack_d   = 1'b0;
    spi_rdata_d = spi_rdata_q;
    resp_go     = 1'b0;
    resp_data   = '0;

    case (state_q)
      ST_IDLE: begin
        if (gnt[REQ_WB]) begin
          src_d = GNT_WB;
          if (wb_hit) begin
            reg_en_d    = 1'b1;
            reg_we_d    = wb.wbs_we_i;
            reg_be_d    = wb.wbs_sel_i;
            reg_addr_d  = wb.wbs_adr_i[ADDR_W+1:2];
            reg_wdata_d = DATA_W'(wb.wbs_dat_i);
            state_d     = ST_ISSUE;
          end else begin
            // Out of window: answer at once with zero so the bus never hangs.
            resp_go = 1'b1;
            state_d = ST_RESP;
          end
        end else if (gnt[REQ_SPI]) begin
          src_d       = GNT_SPI;
          reg_en_d    = 1'b1;
          reg_we_d    = spi_we;
          reg_be_d    = 4'hF;
          reg_addr_d  = spi_addr;
          reg_wdata_d = spi_wdata;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (reg_we_q) begin
          resp_go = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d   = CNT_INIT;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 2'd0) begin
          resp_go   = 1'b1;
          resp_data = reg_rdata;
          state_d   = ST_RESP;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Route the completion to whichever side owns this access.
    if (resp_go) begin
      if (src_d == GNT_WB) begin
        wb_ack_d = 1'b1;
        wb_dat_d = 32'(resp_data);
      end else begin
        spi_ack_d   = 1'b1;
        spi_rdata_d = resp_data;
      end
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset aborts any access in flight.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 2'd0;
      src_q       <= GNT_WB;
      reg_en_q    <= 1'b0;
      reg_we_q    <= 1'b0;
      reg_be_q    <= 4'h0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      wb_ack_q    <= 1'b0;
      wb_dat_q    <= '0;
      spi_ack_q   <= 1'b0;
      spi_rdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      src_q       <= src_d;
      reg_en_q    <= reg_en_d;
      reg_we_q    <= reg_we_d;
      reg_be_q    <= reg_be_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      wb_ack_q    <= wb_ack_d;
      wb_dat_q    <= wb_dat_d;
      spi_ack_q   <= spi_ack_d;
      spi_rdata_q <= spi_rdata_d;
      busy_q      <= busy_d;
    end
  end

  // A master that drops cyc during RESP has abandoned the cycle: no ack.
  assign wb.wbs_ack_o = wb_ack_q & wb.wbs_cyc_i;
  assign wb.wbs_dat_o = wb_dat_q;
  assign spi_ack      = spi_ack_q;
  assign spi_rdata    = spi_rdata_q;
  assign reg_en       = reg_en_q;
  assign reg_we       = reg_we_q;
  assign reg_be       = reg_be_q;
  assign reg_addr     = reg_addr_q;
  assign reg_wdata    = reg_wdata_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_rap_reg_arbiter.sv
// Self-checking bench for rap_reg_arbiter: directed scenarios plus randomized
// traffic checked against a word-level register-file reference.
module tb_rap_reg_arbiter;
  import rap_reg_pkg::*;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc_n = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  // DUT with RD_LATENCY = 1 (main target)
  rap_reg_arbiter_if wb1 ();
  logic              spi_req1, spi_we1;
  logic [ADDR_W-1:0] spi_addr1;
  logic [DATA_W-1:0] spi_wdata1, spi_rdata1, reg_wdata1, reg_rdata1;
  logic              spi_ack1, reg_en1, reg_we1, busy1;
  logic [3:0]        reg_be1;
  logic [ADDR_W-1:0] reg_addr1;

  rap_reg_arbiter #(.RD_LATENCY(1)) u_dut1 (
    .wb_clk_i (clk), .wb_rst_n (rst_n), .wb (wb1.slave),
    .spi_req (spi_req1), .spi_we (spi_we1), .spi_addr (spi_addr1), .spi_wdata (spi_wdata1),
    .spi_ack (spi_ack1), .spi_rdata (spi_rdata1),
    .reg_en (reg_en1), .reg_we (reg_we1), .reg_be (reg_be1), .reg_addr (reg_addr1),
    .reg_wdata (reg_wdata1), .reg_rdata (reg_rdata1), .busy (busy1)
  );

  // DUT with RD_LATENCY = 3 (Wishbone reads only)
  rap_reg_arbiter_if wb3 ();
  logic              spi_ack3, reg_en3, reg_we3, busy3;
  logic [DATA_W-1:0] spi_rdata3, reg_wdata3, reg_rdata3;
  logic [3:0]        reg_be3;
  logic [ADDR_W-1:0] reg_addr3;

  rap_reg_arbiter #(.RD_LATENCY(3)) u_dut3 (
    .wb_clk_i (clk), .wb_rst_n (rst_n), .wb (wb3.slave),
    .spi_req (1'b0), .spi_we (1'b0), .spi_addr ('0), .spi_wdata ('0),
    .spi_ack (spi_ack3), .spi_rdata (spi_rdata3),
    .reg_en (reg_en3), .reg_we (reg_we3), .reg_be (reg_be3), .reg_addr (reg_addr3),
    .reg_wdata (reg_wdata3), .reg_rdata (reg_rdata3), .busy (busy3)
  );

  // Register-file model: byte-enabled writes, reads returned after the
  // configured latency with random filler on every other cycle.
  bit [31:0] mem [256];
  bit [31:0] pipe1;
  bit [31:0] pipe3 [3];

  always @(posedge clk) begin
    if (reg_en1 === 1'b1 && reg_we1 === 1'b1)
      for (int b = 0; b < 4; b++)
        if (reg_be1[b]) mem[reg_addr1][b*8 +: 8] <= reg_wdata1[b*8 +: 8];
    pipe1    <= (reg_en1 === 1'b1 && reg_we1 === 1'b0) ? mem[reg_addr1] : $urandom;
    pipe3[0] <= (reg_en3 === 1'b1 && reg_we3 === 1'b0) ? mem[reg_addr3] : $urandom;
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign reg_rdata1 = pipe1;
  assign reg_rdata3 = pipe3[2];

  // Reference register contents, updated from the access rules alone.
  bit [31:0] ref_mem [256];

  // Observation log for DUT1 (recorded mid-cycle).
  int                en_cnt1 = 0, wback_cnt1 = 0, spiack_cnt1 = 0, en_cyc1 = 0;
  logic [ADDR_W-1:0] en_addr1;
  logic              en_we1;
  logic [3:0]        en_be1;
  logic [31:0]       en_wdata1;
  logic [7:0]        ack_log [$];

  always @(negedge clk) begin
    if (reg_en1 === 1'b1) begin
      en_cnt1   <= en_cnt1 + 1;
      en_cyc1   <= cyc_n;
      en_addr1  <= reg_addr1;
      en_we1    <= reg_we1;
      en_be1    <= reg_be1;
      en_wdata1 <= reg_wdata1;
    end
    if (wb1.wbs_ack_o === 1'b1) begin
      wback_cnt1 <= wback_cnt1 + 1;
      ack_log.push_back("W");
    end
    if (spi_ack1 === 1'b1) begin
      spiack_cnt1 <= spiack_cnt1 + 1;
      ack_log.push_back("S");
    end
  end

  task automatic wb_xact(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                         input logic we, output int t0, output int ack_rel, output logic [31:0] rdat);
    @(posedge clk); #1;
    wb1.wbs_cyc_i = 1'b1; wb1.wbs_stb_i = 1'b1; wb1.wbs_we_i = we;
    wb1.wbs_sel_i = sel;  wb1.wbs_adr_i = adr;  wb1.wbs_dat_i = dat;
    t0 = cyc_n; ack_rel = -1; rdat = 32'hxxxx_xxxx;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (wb1.wbs_ack_o === 1'b1) begin
        ack_rel = cyc_n - t0; rdat = wb1.wbs_dat_o;
        break;
      end
    end
    @(posedge clk); #1;
    wb1.wbs_cyc_i = 1'b0; wb1.wbs_stb_i = 1'b0; wb1.wbs_we_i = 1'b0;
    if (we && ((adr & WB_MASK_DEF) == WB_BASE_DEF))
      for (int b = 0; b < 4; b++)
        if (sel[b]) ref_mem[adr[9:2]][b*8 +: 8] = dat[b*8 +: 8];
  endtask

  task automatic spi_xact(input logic [7:0] addr, input logic [31:0] dat, input logic we,
                          output int t0, output int ack_rel, output logic [31:0] rdat);
    @(posedge clk); #1;
    spi_req1 = 1'b1; spi_we1 = we; spi_addr1 = addr; spi_wdata1 = dat;
    t0 = cyc_n; ack_rel = -1; rdat = 32'hxxxx_xxxx;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (spi_ack1 === 1'b1) begin
        ack_rel = cyc_n - t0; rdat = spi_rdata1;
        break;
      end
    end
    @(posedge clk); #1;
    spi_req1 = 1'b0; spi_we1 = 1'b0;
    if (we) ref_mem[addr] = dat;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ((|{reg_en1, reg_we1, reg_be1, reg_addr1, reg_wdata1, wb1.wbs_ack_o, wb1.wbs_dat_o,
           spi_ack1, spi_rdata1}) !== 1'b0)
      $display("FAIL reset_outputs1: some output nonzero, required all 0");
    else n_pass++;
    n_checks++;
    if ((|{reg_en3, reg_we3, reg_be3, reg_addr3, reg_wdata3, wb3.wbs_ack_o, wb3.wbs_dat_o,
           spi_ack3, spi_rdata3, busy3}) !== 1'b0)
      $display("FAIL reset_outputs3: some output nonzero, required all 0");
    else n_pass++;
    n_checks++;
    if (busy1 !== 1'b0) $display("FAIL reset_busy: got %b required 0", busy1); else n_pass++;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (busy1 !== 1'b0) $display("FAIL idle_busy: got %b required 0", busy1); else n_pass++;
  endtask

  task automatic test_wb_write();
    int t0, rel, en0, ack0;
    logic [31:0] rd;
    en0 = en_cnt1; ack0 = wback_cnt1;
    wb_xact(32'h3000_0010, 32'hDEAD_BEEF, 4'hF, 1'b1, t0, rel, rd);
    repeat (2) @(posedge clk); #1;
    n_checks++;
    if (rel !== 2) $display("FAIL wr_ack_cycle: got %0d required 2", rel); else n_pass++;
    n_checks++;
    if (en_cnt1 - en0 !== 1) $display("FAIL wr_en_count: got %0d required 1", en_cnt1 - en0); else n_pass++;
    n_checks++;
    if (en_cyc1 - t0 !== 1) $display("FAIL wr_en_cycle: got %0d required 1", en_cyc1 - t0); else n_pass++;
    n_checks++;
    if (en_addr1 !== 8'd4) $display("FAIL wr_addr: got %h required 04", en_addr1); else n_pass++;
    n_checks++;
    if (en_we1 !== 1'b1 || en_be1 !== 4'hF) $display("FAIL wr_we_be: got %b/%h required 1/f", en_we1, en_be1); else n_pass++;
    n_checks++;
    if (en_wdata1 !== 32'hDEAD_BEEF) $display("FAIL wr_wdata: got %h required deadbeef", en_wdata1); else n_pass++;
    n_checks++;
    if (wback_cnt1 - ack0 !== 1) $display("FAIL wr_ack_once: got %0d acks required 1", wback_cnt1 - ack0); else n_pass++;
    n_checks++;
    if (rd !== 32'h0) $display("FAIL wr_rdata: got %h required 0", rd); else n_pass++;
  endtask

  task automatic test_wb_read();
    int t0, rel;
    logic [31:0] rd;
    wb_xact(32'h3000_0008, 32'h1234_5678, 4'hF, 1'b1, t0, rel, rd);
    wb_xact(32'h3000_0008, 32'h0, 4'hF, 1'b0, t0, rel, rd);
    #1;
    n_checks++;
    if (rel !== 3) $display("FAIL rd_ack_cycle: got %0d required 3", rel); else n_pass++;
    n_checks++;
    if (rd !== 32'h1234_5678) $display("FAIL rd_data: got %h required 12345678", rd); else n_pass++;
    n_checks++;
    if (en_addr1 !== 8'd2 || en_we1 !== 1'b0) $display("FAIL rd_addr: got %h/%b required 02/0", en_addr1, en_we1); else n_pass++;
  endtask

  task automatic test_wb_read_lat3();
    int t0, rel, en_rel;
    logic [31:0] rd;
    logic [7:0] ea;
    @(posedge clk); #1;
    wb3.wbs_cyc_i = 1'b1; wb3.wbs_stb_i = 1'b1; wb3.wbs_we_i = 1'b0;
    wb3.wbs_sel_i = 4'hF; wb3.wbs_adr_i = 32'h3000_0008; wb3.wbs_dat_i = 32'h0;
    t0 = cyc_n; rel = -1; en_rel = -1; rd = 32'hx; ea = 8'hxx;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (reg_en3 === 1'b1) begin en_rel = cyc_n - t0; ea = reg_addr3; end
      if (wb3.wbs_ack_o === 1'b1) begin rel = cyc_n - t0; rd = wb3.wbs_dat_o; break; end
    end
    @(posedge clk); #1;
    wb3.wbs_cyc_i = 1'b0; wb3.wbs_stb_i = 1'b0;
    n_checks++;
    if (rel !== 5) $display("FAIL rd3_ack_cycle: got %0d required 5", rel); else n_pass++;
    n_checks++;
    if (rd !== ref_mem[2]) $display("FAIL rd3_data: got %h required %h", rd, ref_mem[2]); else n_pass++;
    n_checks++;
    if (en_rel !== 1 || ea !== 8'd2) $display("FAIL rd3_en: got cycle %0d addr %h required 1/02", en_rel, ea); else n_pass++;
  endtask

  task automatic test_out_of_window();
    int t0, rel, en0;
    logic [31:0] rd;
    logic [31:0] adrs [3] = '{32'h2000_0000, 32'h3000_0400, 32'h2FFF_FFFC};
    for (int k = 0; k < 3; k++) begin
      en0 = en_cnt1;
      wb_xact(adrs[k], 32'hFFFF_FFFF, 4'hF, k[0], t0, rel, rd);
      @(posedge clk); #1;
      n_checks++;
      if (rel !== 1) $display("FAIL oow_ack_cycle %h: got %0d required 1", adrs[k], rel); else n_pass++;
      n_checks++;
      if (rd !== 32'h0) $display("FAIL oow_data %h: got %h required 0", adrs[k], rd); else n_pass++;
      n_checks++;
      if (en_cnt1 !== en0) $display("FAIL oow_no_en %h: got %0d strobes required 0", adrs[k], en_cnt1 - en0); else n_pass++;
    end
    // Last word of the window is still in range.
    wb_xact(32'h3000_03FC, 32'hCAFE_F00D, 4'hF, 1'b1, t0, rel, rd);
    #1;
    n_checks++;
    if (rel !== 2 || en_addr1 !== 8'hFF) $display("FAIL window_top: got ack %0d addr %h required 2/ff", rel, en_addr1); else n_pass++;
  endtask

  task automatic test_spi();
    int t0, rel;
    logic [31:0] rd;
    spi_xact(8'h02, 32'h0, 1'b0, t0, rel, rd);
    n_checks++;
    if (rel !== 3 || rd !== ref_mem[2]) $display("FAIL spi_read: got cycle %0d data %h required 3/%h", rel, rd, ref_mem[2]); else n_pass++;
    spi_xact(8'h7F, 32'hA5A5_A5A5, 1'b1, t0, rel, rd);
    repeat (2) @(posedge clk); #1;
    n_checks++;
    if (rel !== 2) $display("FAIL spi_wr_ack_cycle: got %0d required 2", rel); else n_pass++;
    n_checks++;
    if (rd !== 32'h0) $display("FAIL spi_wr_rdata: got %h required 0", rd); else n_pass++;
    n_checks++;
    if (en_be1 !== 4'hF || en_addr1 !== 8'h7F || en_we1 !== 1'b1) $display("FAIL spi_wr_fields: got be %h addr %h we %b required f/7f/1", en_be1, en_addr1, en_we1); else n_pass++;
    n_checks++;
    if (en_wdata1 !== 32'hA5A5_A5A5) $display("FAIL spi_wr_wdata: got %h required a5a5a5a5", en_wdata1); else n_pass++;
    n_checks++;
    if (spi_ack1 !== 1'b0) $display("FAIL spi_ack_pulse: got %b required 0 after ack", spi_ack1); else n_pass++;
  endtask

  task automatic test_abort();
    int ack0;
    @(posedge clk); #1;
    ack0 = wback_cnt1;
    wb1.wbs_cyc_i = 1'b1; wb1.wbs_stb_i = 1'b1; wb1.wbs_we_i = 1'b0;
    wb1.wbs_sel_i = 4'hF; wb1.wbs_adr_i = 32'h3000_0008;
    repeat (3) @(posedge clk);
    #1 wb1.wbs_cyc_i = 1'b0; wb1.wbs_stb_i = 1'b0;
    repeat (4) @(posedge clk); #1;
    n_checks++;
    if (wback_cnt1 !== ack0) $display("FAIL abort_no_ack: got %0d acks required 0", wback_cnt1 - ack0); else n_pass++;
    n_checks++;
    if (busy1 !== 1'b0) $display("FAIL abort_idle: got busy %b required 0", busy1); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int ack0, en0, t0, rel;
    logic [31:0] rd;
    @(posedge clk); #1;
    wb1.wbs_cyc_i = 1'b1; wb1.wbs_stb_i = 1'b1; wb1.wbs_we_i = 1'b0;
    wb1.wbs_sel_i = 4'hF; wb1.wbs_adr_i = 32'h3000_0010;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (busy1 !== 1'b1) $display("FAIL midrst_busy_before: got %b required 1", busy1); else n_pass++;
    rst_n = 1'b0;
    wb1.wbs_cyc_i = 1'b0; wb1.wbs_stb_i = 1'b0;
    #1;
    n_checks++;
    if ((|{reg_en1, reg_we1, reg_be1, reg_addr1, reg_wdata1, wb1.wbs_ack_o, wb1.wbs_dat_o,
           spi_ack1, spi_rdata1, busy1}) !== 1'b0)
      $display("FAIL midrst_outputs: some output nonzero, required all 0");
    else n_pass++;
    ack0 = wback_cnt1; en0 = en_cnt1;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (6) @(posedge clk); #1;
    n_checks++;
    if (wback_cnt1 !== ack0 || en_cnt1 !== en0) $display("FAIL midrst_quiet: got %0d acks %0d strobes required 0/0", wback_cnt1 - ack0, en_cnt1 - en0); else n_pass++;
    wb_xact(32'h3000_0010, 32'h0, 4'hF, 1'b0, t0, rel, rd);
    n_checks++;
    if (rel !== 3 || rd !== ref_mem[4]) $display("FAIL midrst_recover: got cycle %0d data %h required 3/%h", rel, rd, ref_mem[4]); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int base;
    logic [7:0] exp_log [6];
    logic [7:0] last;
    do_reset();
    base = ack_log.size();
    // Both sides keep requesting, so each grant goes to the side not served last.
    last = "S";
    for (int k = 0; k < 6; k++) begin
      exp_log[k] = (last == "S") ? "W" : "S";
      last = exp_log[k];
    end
    fork
      begin
        int t0, rel; logic [31:0] rd;
        for (int k = 0; k < 3; k++)
          wb_xact(32'h3000_0100 + 32'(k * 4), $urandom, 4'hF, 1'b1, t0, rel, rd);
      end
      begin
        int t0, rel; logic [31:0] rd;
        for (int k = 0; k < 3; k++)
          spi_xact(8'h50 + 8'(k), $urandom, 1'b1, t0, rel, rd);
      end
    join
    repeat (2) @(posedge clk); #1;
    n_checks++;
    if (ack_log.size() - base !== 6) $display("FAIL rr_count: got %0d completions required 6", ack_log.size() - base);
    else begin
      n_pass++;
      for (int k = 0; k < 6; k++) begin
        n_checks++;
        if (ack_log[base + k] !== exp_log[k]) $display("FAIL rr_order[%0d]: got %s required %s", k, ack_log[base + k], exp_log[k]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_random();
    int t0, rel, en0, kind, exp_rel, exp_en;
    logic [31:0] rd, exp_d, adr, dat;
    logic [7:0] idx;
    logic [3:0] sel;
    logic we, hit;
    for (int n = 0; n < 24; n++) begin
      kind = $urandom_range(0, 4);
      idx  = 8'($urandom_range(0, 15));
      dat  = $urandom;
      sel  = 4'($urandom_range(1, 15));
      we   = (kind == 0) || (kind == 3) || ((kind == 2) && $urandom_range(0, 1) == 1);
      adr  = (kind == 2) ? $urandom : (WB_BASE_DEF | {22'd0, idx, 2'b00});
      if ((kind == 2) && ((adr & WB_MASK_DEF) == WB_BASE_DEF)) adr = adr ^ 32'h1000_0000;
      hit  = (adr & WB_MASK_DEF) == WB_BASE_DEF;
      exp_rel = (kind <= 2 && !hit) ? 1 : (we ? 2 : 2 + 1);
      exp_en  = (kind <= 2 && !hit) ? 0 : 1;
      exp_d   = (we || (kind <= 2 && !hit)) ? 32'h0 : ref_mem[idx];
      en0 = en_cnt1;
      if (kind <= 2) wb_xact(adr, dat, sel, we, t0, rel, rd);
      else           spi_xact(idx, dat, we, t0, rel, rd);
      @(posedge clk); #1;
      n_checks++;
      if (rel !== exp_rel) $display("FAIL rand%0d_latency kind %0d: got %0d required %0d", n, kind, rel, exp_rel); else n_pass++;
      n_checks++;
      if (rd !== exp_d) $display("FAIL rand%0d_data kind %0d: got %h required %h", n, kind, rd, exp_d); else n_pass++;
      n_checks++;
      if (en_cnt1 - en0 !== exp_en) $display("FAIL rand%0d_strobes kind %0d: got %0d required %0d", n, kind, en_cnt1 - en0, exp_en); else n_pass++;
    end
  endtask

  initial begin
    wb1.wbs_cyc_i = 1'b0; wb1.wbs_stb_i = 1'b0; wb1.wbs_we_i = 1'b0;
    wb1.wbs_sel_i = 4'h0; wb1.wbs_adr_i = 32'h0; wb1.wbs_dat_i = 32'h0;
    wb3.wbs_cyc_i = 1'b0; wb3.wbs_stb_i = 1'b0; wb3.wbs_we_i = 1'b0;
    wb3.wbs_sel_i = 4'h0; wb3.wbs_adr_i = 32'h0; wb3.wbs_dat_i = 32'h0;
    spi_req1 = 1'b0; spi_we1 = 1'b0; spi_addr1 = '0; spi_wdata1 = '0;

    test_reset();
    test_wb_write();
    test_wb_read();
    test_wb_read_lat3();
    test_out_of_window();
    test_spi();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_random();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rap_reg_arbiter.md
Name: rap_reg_arbiter

Overview:
- Shares the single rapcores configuration/status register-file port between two requesters: the management SoC Wishbone slave (wbs_*) and the SPI command decoder.
- Sequences each access: arbitrate, issue, wait for read data, respond.
- Sits between the user_project_wrapper Wishbone pins, the SPI front end and the motor-control register file.
- Out-of-window Wishbone accesses are terminated locally so the bus never hangs.

Parameters:
- ADDR_W, 8, register-file word-address width
- DATA_W, 32, data width (Wishbone side fixed at 32)
- WB_BASE, 32'h3000_0000, Wishbone window base
- WB_MASK, 32'hFFFF_FC00, window mask; hit when (wbs_adr_i & WB_MASK) == WB_BASE
- RD_LATENCY, 1, reg_rdata valid this many cycles after the reg_en cycle (1..4)

Ports:
- wb_clk_i  in  1  single clock
- wb_rst_n  in  1  asynchronous active-low reset
- wbs_cyc_i  in  1  Wishbone cycle
- wbs_stb_i  in  1  Wishbone strobe
- wbs_we_i  in  1  Wishbone write
- wbs_sel_i  in  4  byte selects
- wbs_adr_i  in  32  byte address
- wbs_dat_i  in  32  write data
- wbs_ack_o  out  1  one-cycle ack
- wbs_dat_o  out  32  read data, valid with ack
- spi_req  in  1  SPI request, level, held until spi_ack
- spi_we  in  1  SPI write
- spi_addr  in  ADDR_W  SPI word address
- spi_wdata  in  DATA_W  SPI write data
- spi_ack  out  1  one-cycle completion
- spi_rdata  out  DATA_W  read data, valid with spi_ack
- reg_en  out  1  register access strobe, one cycle
- reg_we  out  1  write qualifier
- reg_be  out  4  byte enables
- reg_addr  out  ADDR_W  word address
- reg_wdata  out  DATA_W  write data
- reg_rdata  in  DATA_W  read data
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: all outputs 0, state IDLE, last_grant = SPI (so Wishbone wins the first tie).
- Reset asserted mid-transaction aborts it; no ack is issued afterwards.
- Request sources:
  - Wishbone request = wbs_cyc_i & wbs_stb_i.
  - SPI request = spi_req.
- States: IDLE, ISSUE, WAIT, RESP, all outputs registered.
- IDLE:
  - Only one request: grant it.
  - Both requesting: grant the one that is not last_grant (round-robin). last_grant updates on every grant.
  - Wishbone grant, in window: latch reg_addr = wbs_adr_i[ADDR_W+1:2], reg_be = wbs_sel_i, reg_we = wbs_we_i, reg_wdata = wbs_dat_i; go to ISSUE.
  - Wishbone grant, out of window: no reg_en; latch rdata = 0; go directly to RESP.
  - SPI grant: reg_be = 4'hF, address/data from spi_*; go to ISSUE.
- ISSUE: reg_en = 1 for exactly this cycle. Write → RESP. Read → WAIT with counter = RD_LATENCY-1.
- WAIT:
  - Counter at 0: capture reg_rdata, go to RESP.
  - Otherwise: decrement.
  - With RD_LATENCY = 1, reg_rdata is sampled on the edge ending the first WAIT cycle.
- RESP:
  - Pulse wbs_ack_o (with wbs_dat_o) or spi_ack (with spi_rdata) for one cycle, then go to IDLE.
  - wbs_dat_o and spi_rdata hold their last value between acks.
  - Writes return rdata = 0.
- Cycle counts from the request sampled in IDLE (cycle 0):
  - write: reg_en in cycle 1, ack in cycle 2
  - read: ack in cycle 2+RD_LATENCY
  - out-of-window: ack in cycle 1
- Wishbone abort: if wbs_cyc_i is low during RESP of a Wishbone grant, suppress the ack. The register-side access has already completed.
- No double accept: a Wishbone request is sampled only in IDLE. The master drops stb after ack, so the IDLE cycle following RESP sees the next transaction, not a repeat.
- A request arriving while busy waits.
- SPI starvation bound: at most one Wishbone transaction is served between consecutive SPI grants while SPI is requesting.

Decomposition:
- Package rap_reg_pkg holds:
  - state enum (IDLE/ISSUE/WAIT/RESP)
  - grant enum (GNT_WB/GNT_SPI)
  - default ADDR_W, WB_BASE, WB_MASK
- Sub-module rap_rr_arb2: 2-way round-robin arbiter (req[1:0], update, gnt[1:0], internal last-grant register).

Test Plan:
- Wishbone write adr 0x3000_0010, dat 0xDEADBEEF, sel 0xF → reg_en in cycle 1 with reg_addr = 4, reg_we = 1, reg_wdata = 0xDEADBEEF; wbs_ack_o in cycle 2 only.
- Wishbone read adr 0x3000_0008 with model returning 0x12345678 at RD_LATENCY = 1 → reg_addr = 2; ack in cycle 3 with wbs_dat_o = 0x12345678. Repeat with RD_LATENCY = 3 → ack in cycle 5.
- Both requests in the same cycle out of reset → Wishbone served first, then SPI. Three back-to-back pairs alternate WB, SPI, WB, SPI, WB, SPI.
- Wishbone read at 0x2000_0000 (out of window) → no reg_en; ack in cycle 1 with wbs_dat_o = 0.
- SPI write addr 0x7F, data 0xA5A5A5A5 → reg_be = 0xF, spi_ack one cycle in cycle 2; spi_rdata = 0.
- Assert wb_rst_n low during WAIT of a read → all outputs 0 immediately, no ack after release. A new request is served normally afterwards.
